bomberman_map_cmd_engine: RTL and testbench

//  Downstream consumer of the bomberman AXI4-Lite register slave: takes the command mailbox
//  the CPU writes (op, x, y, len, tile) and executes it against the tile-map BRAM port.

---
 rtl/bomberman_map_pkg.sv | 15 +
 rtl/bomberman_map_addr_gen.sv | 41 ++++
 rtl/bomberman_map_cmd_engine.sv | 145 ++++++++++++++
 tb/tb_bomberman_map_cmd_engine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bomberman_map_pkg.sv
// bomberman_map_pkg: shared map geometry defaults, command ops, FSM states, error and tile codes
package bomberman_map_pkg;
  localparam int MAP_W_DEF = 13;
  localparam int MAP_H_DEF = 11;
  localparam int TILE_W_DEF = 4;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [1:0] {OP_WRITE, OP_FILL, OP_READ, OP_CLEAR} op_e;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FILL, S_RD_ISSUE, S_RD_WAIT, S_CLEAR, S_DONE} state_e;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_WALL = 4'd1;
  localparam logic [3:0] TILE_BRICK = 4'd2;
endpackage

// File: rtl/bomberman_map_addr_gen.sv
// bomberman_map_addr_gen: x/y tile counters (load/step/row wrap) -> registered y*MAP_W+x address and end-of-map flag
module bomberman_map_addr_gen
  import bomberman_map_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [3:0]        ld_x,
  input  logic [3:0]        ld_y,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);
  localparam logic [3:0] X_MAX = 4'(MAP_W - 1);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAP_W * MAP_H - 1);
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb begin
    x_d = load ? ld_x : step ? (x_q == X_MAX ? '0 : x_q + 1'b1) : x_q;
    y_d = load ? ld_y : (step && x_q == X_MAX) ? y_q + 1'b1 : y_q;
    addr_d = ADDR_W'(y_d) * W_A + ADDR_W'(x_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
    end
  end
  assign addr = addr_q;
  assign at_end = addr_q == LAST;
endmodule

// File: rtl/bomberman_map_cmd_engine.sv
// bomberman_map_cmd_engine: executes mailbox commands (write/fill/read/clear) against the tile-map BRAM port
module bomberman_map_cmd_engine
  import bomberman_map_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int TILE_W = TILE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [7:0]        cmd_len,
  input  logic [TILE_W-1:0] cmd_tile,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [TILE_W-1:0] mem_wdata,
  input  logic [TILE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [TILE_W-1:0] rd_tile,
  output logic              cmd_drop
);
  localparam logic [3:0] XW = 4'(MAP_W);
  localparam logic [3:0] YH = 4'(MAP_H);
  state_e state_q, state_d;
  logic ready_q, ready_d, busy_q, busy_d, en_q, en_d, we_q, we_d, done_q, done_d, drop_q, drop_d;
  logic [TILE_W-1:0] wdata_q, wdata_d, rd_q, rd_d;
  logic [1:0] err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic ag_load, ag_step, at_end;
  logic [3:0] ag_x, ag_y;
  bomberman_map_addr_gen #(.MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk(clk), .rst(rst), .load(ag_load), .step(ag_step), .ld_x(ag_x), .ld_y(ag_y),
    .addr(mem_addr), .at_end(at_end)
  );
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    we_d = 1'b0;
    wdata_d = wdata_q;
    err_d = err_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    drop_d = drop_q | (cmd_valid & ~ready_q);
    ag_load = 1'b0;
    ag_step = 1'b0;
    ag_x = cmd_op == OP_CLEAR ? '0 : cmd_x;
    ag_y = cmd_op == OP_CLEAR ? '0 : cmd_y;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        drop_d = 1'b0;
        ag_load = 1'b1;
        cnt_d = cmd_len;
        wdata_d = cmd_tile;
        if (cmd_op != OP_CLEAR && (cmd_x >= XW || cmd_y >= YH)) begin
          state_d = S_DONE;
          err_d = ERR_RANGE;
        end else if (cmd_op == OP_FILL && cmd_len == 8'd0) begin
          state_d = S_DONE;
          err_d = ERR_OK;
        end else begin
          state_d = cmd_op == OP_READ ? S_RD_ISSUE : cmd_op == OP_FILL ? S_FILL :
                    cmd_op == OP_CLEAR ? S_CLEAR : S_WRITE;
          en_d = 1'b1;
          we_d = cmd_op != OP_READ;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        err_d = ERR_OK;
      end
      // cnt_q counts the tile being written this cycle; an exact fit to the map end is not an overrun
      S_FILL: if (cnt_q == 8'd1 || at_end) begin
        state_d = S_DONE;
        err_d = cnt_q == 8'd1 ? ERR_OK : ERR_OVERRUN;
      end else begin
        ag_step = 1'b1;
        en_d = 1'b1;
        we_d = 1'b1;
        cnt_d = cnt_q - 8'd1;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_d = mem_rdata;
        state_d = S_DONE;
        err_d = ERR_OK;
      end
      S_CLEAR: if (at_end) begin
        state_d = S_DONE;
        err_d = ERR_OK;
      end else begin
        ag_step = 1'b1;
        en_d = 1'b1;
        we_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = state_d == S_DONE;
    ready_d = state_d == S_IDLE;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
      wdata_q <= TILE_W'(TILE_EMPTY);
      rd_q <= TILE_W'(TILE_EMPTY);
      err_q <= ERR_OK;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      en_q <= en_d;
      we_q <= we_d;
      done_q <= done_d;
      drop_q <= drop_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign cmd_ready = ready_q;
  assign busy = busy_q;
  assign mem_en = en_q;
  assign mem_we = we_q;
  assign mem_wdata = wdata_q;
  assign done = done_q;
  assign err_code = err_q;
  assign rd_tile = rd_q;
  assign cmd_drop = drop_q;
endmodule

// File: tb/tb_bomberman_map_cmd_engine.sv
// tb_bomberman_map_cmd_engine: directed self-checking bench with a behavioural BRAM
module tb_bomberman_map_cmd_engine;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_x = '0, cmd_y = '0, cmd_tile = '0;
  logic [7:0] cmd_len = '0;
  logic cmd_ready, mem_en, mem_we, busy, done, cmd_drop;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata = '0, rd_tile;
  logic [1:0] err_code;
  logic [3:0] mem [256] = '{default: 4'hF};
  int checks = 0, failures = 0, wr_cnt = 0, done_cnt = 0, viol = 0, w0, d0;

  bomberman_map_cmd_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_tile(cmd_tile), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err_code(err_code), .rd_tile(rd_tile), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) wr_cnt++;
    if (done) done_cnt++;
    if (mem_en && mem_addr >= 8'd143) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] len, input logic [3:0] tile);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_len = len; cmd_tile = tile;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_en", mem_en, 0); chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_err", err_code, 0); chk("rst_rd", rd_tile, 0); chk("rst_drop", cmd_drop, 0);
    rst = 1'b0;
    tick();
    // 1: single write at (2,3) -> addr 41
    w0 = wr_cnt;
    send(2'd0, 4'd2, 4'd3, 8'd0, 4'd5);
    chk("w_en", {mem_en, mem_we}, 2'b11); chk("w_addr", mem_addr, 41); chk("w_wdata", mem_wdata, 5);
    chk("w_busy", {busy, cmd_ready, done}, 3'b100);
    tick();
    chk("w_done", done, 1); chk("w_err", err_code, 0); chk("w_en_off", mem_en, 0);
    tick();
    chk("w_idle", {done, cmd_ready}, 2'b01); chk("w_cnt", wr_cnt - w0, 1); chk("w_mem", mem[41], 5);
    // 2: write then read back the last tile (12,10) -> addr 142
    send(2'd0, 4'd12, 4'd10, 8'd0, 4'd7);
    tick(); tick();
    send(2'd2, 4'd12, 4'd10, 8'd0, 4'd0);
    chk("r_issue", {mem_en, mem_we}, 2'b10); chk("r_addr", mem_addr, 142);
    tick();
    chk("r_nodone", done, 0);
    tick();
    chk("r_done", done, 1); chk("r_tile", rd_tile, 7); chk("r_err", err_code, 0);
    tick();
    // 3: fill across a row boundary
    send(2'd1, 4'd11, 4'd0, 8'd4, 4'd1);
    for (int i = 0; i < 4; i++) begin
      chk("f_en", {mem_en, mem_we}, 2'b11); chk("f_addr", mem_addr, 11 + i);
      tick();
    end
    chk("f_done", done, 1); chk("f_err", err_code, 0); chk("f_en_off", mem_en, 0);
    tick();
    // 4: fill overrunning the end of the map
    w0 = wr_cnt;
    send(2'd1, 4'd10, 4'd10, 8'd5, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("ov_addr", mem_addr, 140 + i); chk("ov_en", {mem_en, mem_we}, 2'b11);
      tick();
    end
    chk("ov_done", done, 1); chk("ov_err", err_code, 2); chk("ov_cnt", wr_cnt - w0, 3);
    tick();
    // out-of-range write
    w0 = wr_cnt;
    send(2'd0, 4'd13, 4'd0, 8'd0, 4'd9);
    chk("oor_done", done, 1); chk("oor_err", err_code, 1); chk("oor_en", mem_en, 0);
    tick();
    chk("oor_cnt", wr_cnt - w0, 0);
    // 5: zero-length fill
    w0 = wr_cnt;
    send(2'd1, 4'd1, 4'd1, 8'd0, 4'd4);
    chk("f0_done", done, 1); chk("f0_err", err_code, 0); chk("f0_en", mem_en, 0);
    tick();
    chk("f0_cnt", wr_cnt - w0, 0);
    // clear with a command pulsed mid-run that must be dropped
    w0 = wr_cnt;
    send(2'd3, 4'd5, 4'd5, 8'd99, 4'd0);
    cmd_op = 2'd0; cmd_x = 4'd0; cmd_y = 4'd0; cmd_tile = 4'd9;
    for (int i = 0; i < 143; i++) begin
      chk("c_addr", mem_addr, i); chk("c_en", {mem_en, mem_we}, 2'b11);
      cmd_valid = (i == 70);
      tick();
    end
    cmd_valid = 1'b0;
    chk("c_done", done, 1); chk("c_err", err_code, 0); chk("c_drop", cmd_drop, 1);
    tick(); tick(); tick();
    chk("c_cnt", wr_cnt - w0, 143); chk("c_mem0", mem[0], 0); chk("c_mem142", mem[142], 0);
    chk("c_idle", {busy, cmd_ready}, 2'b01);
    // 6: reset in the middle of a clear
    send(2'd3, 4'd0, 4'd0, 8'd0, 4'd6);
    chk("c2_drop_clr", cmd_drop, 0);
    repeat (49) tick();
    chk("c2_addr49", mem_addr, 49);
    rst = 1'b1;
    tick();
    chk("rs_en", {mem_en, mem_we}, 2'b00); chk("rs_busy", busy, 0); chk("rs_ready", cmd_ready, 1);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (5) tick();
    chk("rs_nodone", done_cnt - d0, 0);
    chk("rs_mem48", mem[48], 6); chk("rs_mem49", mem[49], 6); chk("rs_mem50", mem[50], 0);
    send(2'd0, 4'd4, 4'd2, 8'd0, 4'hA);
    chk("rw_addr", mem_addr, 30); chk("rw_en", {mem_en, mem_we}, 2'b11);
    tick();
    chk("rw_done", done, 1); chk("rw_err", err_code, 0);
    tick();
    chk("rw_mem", mem[30], 4'hA);
    chk("addr_range", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
